// File: rtl/player_activity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : player_activity
// Description : Player-side engine for the typing game. Compares each
//               released keystroke against the current target word from an
//               internal word ROM, tracks lives and score, and sequences the
//               game through start, play, word-complete and game-over phases.
//               Optional build macro: SCORE_SATURATE_EN (score holds at 127
//               instead of wrapping to 0).
// Revision    : 1.0 - initial release
// ============================================================================
module player_activity #(
    parameter int         NUM_WORDS   = 8,
    parameter logic [1:0] START_LIVES = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] keystroke,
    input  logic       keyReleased,
    output logic       wordComplete,
    output logic       gameOver,
    output logic       newGame,
    output logic [2:0] currentState,
    output logic [2:0] nextState,
    output logic [6:0] score,
    output logic [1:0] lives
);

    localparam int               IDX_W            = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IDX_W-1:0] c_LAST_IDX       = IDX_W'(NUM_WORDS - 1);
    localparam logic [4:0]       c_KEY_NONE       = 5'd0;
    localparam logic [4:0]       c_KEY_MAX_LETTER = 5'd26;
    localparam logic [4:0]       c_KEY_RESTART    = 5'd31;
`ifdef SCORE_SATURATE_EN
    localparam logic [6:0]       c_SCORE_MAX      = 7'd127;
`endif

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_L0   = 3'd1,
        S_L1   = 3'd2,
        S_L2   = 3'd3,
        S_L3   = 3'd4,
        S_DONE = 3'd5,
        S_OVER = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic             kr_q;
    logic [6:0]       score_q, score_d;
    logic [1:0]       lives_q, lives_d;
    logic [IDX_W-1:0] widx_q,  widx_d;

    logic             w_event;
    logic             w_restart;
    logic             w_is_letter;
    logic             w_wrong;
    logic [19:0]      w_word;
    logic [4:0]       w_exp_letter;

    // Word ROM: letter k sits at bits [5k+4:5k], letter 0 is typed first.
    function automatic logic [19:0] rom_word(input logic [IDX_W-1:0] idx);
        case (int'(idx))
            0:       rom_word = {5'd10, 5'd18, 5'd11, 5'd4 };
            1:       rom_word = {5'd19, 5'd20, 5'd1,  5'd3 };
            2:       rom_word = {5'd8,  5'd19, 5'd9,  5'd6 };
            3:       rom_word = {5'd20, 5'd1,  5'd15, 5'd2 };
            4:       rom_word = {5'd14, 5'd15, 5'd15, 5'd13};
            5:       rom_word = {5'd18, 5'd1,  5'd20, 5'd19};
            6:       rom_word = {5'd4,  5'd18, 5'd15, 5'd23};
            7:       rom_word = {5'd5,  5'd13, 5'd1,  5'd7 };
            default: rom_word = {5'd10, 5'd18, 5'd11, 5'd4 };
        endcase
    endfunction

    // One event per rising transition of the release strobe.
    assign w_event     = keyReleased & ~kr_q;
    assign w_restart   = w_event && (keystroke == c_KEY_RESTART);
    assign w_is_letter = (keystroke != c_KEY_NONE) && (keystroke <= c_KEY_MAX_LETTER);
    assign w_word      = rom_word(widx_q);

    // Pick the letter the player is expected to type in the current phase.
    always_comb begin
        w_exp_letter = 5'd0;
        case (state_q)
            S_L0:    w_exp_letter = w_word[4:0];
            S_L1:    w_exp_letter = w_word[9:5];
            S_L2:    w_exp_letter = w_word[14:10];
            S_L3:    w_exp_letter = w_word[19:15];
            default: w_exp_letter = 5'd0;
        endcase
    end

    // Next-state decode; restart overrides everything, including a life loss.
    always_comb begin
        state_d = state_q;
        w_wrong = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_L0;
            S_L0, S_L1, S_L2, S_L3: begin
                if (w_event) begin
                    if (keystroke == w_exp_letter) begin
                        case (state_q)
                            S_L0:    state_d = S_L1;
                            S_L1:    state_d = S_L2;
                            S_L2:    state_d = S_L3;
                            default: state_d = S_DONE;
                        endcase
                    end else if (w_is_letter) begin
                        w_wrong = 1'b1;
                        if (lives_q == 2'd1) begin
                            state_d = S_OVER;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_L0;
            S_OVER:  state_d = S_OVER;
            default: state_d = S_IDLE;
        endcase
        if (w_restart) begin
            state_d = S_IDLE;
            w_wrong = 1'b0;
        end
    end

    // Score, lives and word index follow the state transition being taken.
    always_comb begin
        score_d = score_q;
        lives_d = lives_q;
        widx_d  = widx_q;
        if (state_d == S_IDLE) begin
            score_d = 7'd0;
            lives_d = START_LIVES;
            widx_d  = '0;
        end else begin
            if (state_d == S_DONE) begin
                widx_d = (widx_q == c_LAST_IDX) ? '0 : widx_q + IDX_W'(1);
`ifdef SCORE_SATURATE_EN
                score_d = (score_q == c_SCORE_MAX) ? c_SCORE_MAX : score_q + 7'd1;
`else
                score_d = score_q + 7'd1;
`endif
            end
            if (w_wrong) begin
                lives_d = lives_q - 2'd1;
            end
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            kr_q    <= 1'b0;
            score_q <= 7'd0;
            lives_q <= START_LIVES;
            widx_q  <= '0;
        end else begin
            state_q <= state_d;
            kr_q    <= keyReleased;
            score_q <= score_d;
            lives_q <= lives_d;
            widx_q  <= widx_d;
        end
    end

    assign currentState = state_q;
    assign nextState    = state_d;
    assign newGame      = (state_q == S_IDLE);
    assign wordComplete = (state_q == S_DONE);
    assign gameOver     = (state_q == S_OVER);
    assign score        = score_q;
    assign lives        = lives_q;

endmodule
`default_nettype wire

// File: tb/tb_player_activity.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_player_activity
// Description : Self-checking bench for player_activity: directed vector
//               table, hand-written corner sequences, and random stimulus
//               compared against a phase/position reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_player_activity;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] keystroke = 5'd0;
    logic       keyReleased = 1'b0;
    logic       wordComplete, gameOver, newGame;
    logic [2:0] currentState, nextState;
    logic [6:0] score;
    logic [1:0] lives;

    int checks = 0;
    int errors = 0;

    player_activity #(.NUM_WORDS(8), .START_LIVES(2'd3)) dut (
        .clk(clk), .reset(reset), .keystroke(keystroke), .keyReleased(keyReleased),
        .wordComplete(wordComplete), .gameOver(gameOver), .newGame(newGame),
        .currentState(currentState), .nextState(nextState),
        .score(score), .lives(lives)
    );

    always #5 clk = ~clk;

    // Reference words in typing order.
    int words [8][4] = '{
        '{4, 11, 18, 10}, '{3, 1, 20, 19}, '{6, 9, 19, 8},  '{2, 15, 1, 20},
        '{13, 15, 15, 14}, '{19, 20, 1, 18}, '{23, 15, 18, 4}, '{7, 1, 13, 5}
    };

    localparam int P_IDLE = 0, P_PLAY = 1, P_DONE = 2, P_OVER = 3;

    typedef struct {
        int phase;
        int pos;
        int lives;
        int score;
        int widx;
        bit kr;
    } mdl_t;

    mdl_t m;

    function automatic mdl_t model_init();
        mdl_t s;
        s.phase = P_IDLE; s.pos = 0; s.lives = 3; s.score = 0; s.widx = 0; s.kr = 1'b0;
        return s;
    endfunction

    function automatic int next_score(int sc);
`ifdef SCORE_SATURATE_EN
        return (sc >= 127) ? 127 : sc + 1;
`else
        return (sc + 1) % 128;
`endif
    endfunction

    // One clock of the game rules applied to the model.
    function automatic mdl_t mstep(mdl_t s, int ks, bit kr);
        mdl_t n;
        bit   ev;
        n    = s;
        ev   = kr && !s.kr;
        n.kr = kr;
        if (ev && ks == 31) begin
            n.phase = P_IDLE; n.pos = 0; n.lives = 3; n.score = 0; n.widx = 0;
            return n;
        end
        case (s.phase)
            P_IDLE: begin n.phase = P_PLAY; n.pos = 0; end
            P_PLAY: begin
                if (ev) begin
                    if (ks == words[s.widx][s.pos]) begin
                        if (s.pos == 3) begin
                            n.phase = P_DONE;
                            n.widx  = (s.widx + 1) % 8;
                            n.score = next_score(s.score);
                        end else begin
                            n.pos = s.pos + 1;
                        end
                    end else if (ks >= 1 && ks <= 26) begin
                        n.lives = s.lives - 1;
                        if (n.lives == 0) n.phase = P_OVER;
                    end
                end
            end
            P_DONE: begin n.phase = P_PLAY; n.pos = 0; end
            default: ;
        endcase
        return n;
    endfunction

    function automatic int scode(mdl_t s);
        case (s.phase)
            P_IDLE:  return 0;
            P_PLAY:  return 1 + s.pos;
            P_DONE:  return 5;
            default: return 6;
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic chk_model();
        chk("currentState", currentState, scode(m));
        chk("score",        score,        m.score);
        chk("lives",        lives,        m.lives);
        chk("newGame",      newGame,      (m.phase == P_IDLE) ? 1 : 0);
        chk("wordComplete", wordComplete, (m.phase == P_DONE) ? 1 : 0);
        chk("gameOver",     gameOver,     (m.phase == P_OVER) ? 1 : 0);
    endtask

    // Drive inputs on the falling edge, check nextState, clock, check outputs.
    task automatic cycle(input int ks, input bit kr);
        mdl_t nx;
        @(negedge clk);
        keystroke   = 5'(ks);
        keyReleased = kr;
        #1;
        nx = mstep(m, ks, kr);
        chk("nextState", nextState, scode(nx));
        @(posedge clk);
        m = nx;
        #1;
        chk_model();
    endtask

    typedef struct {
        int ks; int kr; int st; int lv; int sc; int wc; int go; int ng;
    } vec_t;

    vec_t tbl [27];
    int   wc_cnt;
    int   r;
    int   ks_r;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl = '{
            //  ks  kr st lv sc wc go ng
            '{  0, 0, 1, 3, 0, 0, 0, 0},
            '{  4, 1, 2, 3, 0, 0, 0, 0},
            '{  4, 0, 2, 3, 0, 0, 0, 0},
            '{ 11, 1, 3, 3, 0, 0, 0, 0},
            '{  0, 0, 3, 3, 0, 0, 0, 0},
            '{ 18, 1, 4, 3, 0, 0, 0, 0},
            '{  0, 0, 4, 3, 0, 0, 0, 0},
            '{ 10, 1, 5, 3, 1, 1, 0, 0},
            '{  0, 0, 1, 3, 1, 0, 0, 0},
            '{  5, 1, 1, 2, 1, 0, 0, 0},
            '{  0, 0, 1, 2, 1, 0, 0, 0},
            '{  3, 1, 2, 2, 1, 0, 0, 0},
            '{  0, 0, 2, 2, 1, 0, 0, 0},
            '{  9, 1, 2, 1, 1, 0, 0, 0},
            '{  0, 0, 2, 1, 1, 0, 0, 0},
            '{  0, 1, 2, 1, 1, 0, 0, 0},
            '{  0, 0, 2, 1, 1, 0, 0, 0},
            '{ 27, 1, 2, 1, 1, 0, 0, 0},
            '{  0, 0, 2, 1, 1, 0, 0, 0},
            '{ 26, 1, 6, 0, 1, 0, 1, 0},
            '{  0, 0, 6, 0, 1, 0, 1, 0},
            '{  0, 1, 6, 0, 1, 0, 1, 0},
            '{  0, 0, 6, 0, 1, 0, 1, 0},
            '{  4, 1, 6, 0, 1, 0, 1, 0},
            '{  0, 0, 6, 0, 1, 0, 1, 0},
            '{ 31, 1, 0, 3, 0, 0, 0, 1},
            '{  0, 1, 1, 3, 0, 0, 0, 0}
        };

        // Reset values.
        m = model_init();
        @(posedge clk);
        #1;
        chk("reset_state",   currentState, 0);
        chk("reset_newGame", newGame,      1);
        chk("reset_lives",   lives,        3);
        chk("reset_score",   score,        0);
        chk("reset_wc",      wordComplete, 0);
        chk("reset_go",      gameOver,     0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 27; i++) begin
            cycle(tbl[i].ks, tbl[i].kr[0]);
            chk($sformatf("vec%0d_state", i), currentState, tbl[i].st);
            chk($sformatf("vec%0d_lives", i), lives,        tbl[i].lv);
            chk($sformatf("vec%0d_score", i), score,        tbl[i].sc);
            chk($sformatf("vec%0d_wc", i),    wordComplete, tbl[i].wc);
            chk($sformatf("vec%0d_go", i),    gameOver,     tbl[i].go);
            chk($sformatf("vec%0d_ng", i),    newGame,      tbl[i].ng);
        end

        // A release level held high yields exactly one event.
        cycle(0, 0);
        for (int i = 0; i < 10; i++) cycle(4, 1);
        chk("hold_single_advance", currentState, 2);
        cycle(0, 0);

        // Restart after a lost life reloads lives rather than decrementing.
        cycle(5, 1);
        cycle(0, 0);
        chk("lives_before_restart", lives, 2);
        cycle(31, 1);
        chk("restart_state", currentState, 0);
        chk("restart_lives", lives, 3);
        cycle(0, 0);

        // Finish a word, then assert reset between clock edges.
        for (int k = 0; k < 4; k++) begin
            cycle(words[0][k], 1);
            cycle(0, 0);
        end
        chk("score_before_async_reset", score, 1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_state", currentState, 0);
        chk("async_reset_score", score,        0);
        chk("async_reset_lives", lives,        3);
        chk("async_reset_ng",    newGame,      1);
        keystroke   = 5'd0;
        keyReleased = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m = model_init();
        cycle(0, 0);

        // 128 complete words: word index wraps every 8, score wraps or saturates.
        wc_cnt = 0;
        for (int w = 0; w < 128; w++) begin
            for (int k = 0; k < 4; k++) begin
                cycle(words[w % 8][k], 1);
                wc_cnt += int'(wordComplete);
                cycle(0, 0);
                wc_cnt += int'(wordComplete);
            end
        end
        chk("words_completed", wc_cnt, 128);
`ifdef SCORE_SATURATE_EN
        chk("score_after_128", score, 127);
`else
        chk("score_after_128", score, 0);
`endif
        // One more word past the boundary.
        for (int k = 0; k < 4; k++) begin
            cycle(words[0][k], 1);
            cycle(0, 0);
        end
`ifdef SCORE_SATURATE_EN
        chk("score_after_129", score, 127);
`else
        chk("score_after_129", score, 1);
`endif

        // Random stimulus against the model.
        for (int i = 0; i < 3000; i++) begin
            r = $urandom_range(0, 99);
            if (m.phase == P_PLAY && r < 55)
                ks_r = words[m.widx][m.pos];
            else if (r < 58 || (m.phase == P_OVER && r < 75))
                ks_r = 31;
            else
                ks_r = $urandom_range(0, 31);
            cycle(ks_r, 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
